// File: rtl/attn_qkv_loader.sv
// attn_qkv_loader: streams Q, K, V elements into three DEPTH-entry matrices for FlashAttention.
// Define KEY_TRANSPOSE_EN to store K transposed (element r,c at key[c*SIZE+r]).
module attn_qkv_loader #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = SIZE * SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  flush,
    input  logic                  qkv_ack,
    output logic                  qkv_valid,
    output logic [1:0]            phase,
    output logic [ADDR_WIDTH-1:0] elem_idx,
    output logic [DATA_WIDTH-1:0] query [DEPTH],
    output logic [DATA_WIDTH-1:0] key   [DEPTH],
    output logic [DATA_WIDTH-1:0] value [DEPTH]
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {LOAD_Q, LOAD_K, LOAD_V, FULL} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx_nxt;
    logic                  last, wr;
    logic [IW-1:0]         wr_idx, key_idx;

    assign in_ready = state != FULL;
    assign phase    = state;
    assign last     = elem_idx == ADDR_WIDTH'(DEPTH - 1);
    assign wr       = in_valid & in_ready & ~flush;
    assign wr_idx   = elem_idx[IW-1:0];

`ifdef KEY_TRANSPOSE_EN
    assign key_idx = IW'((int'(elem_idx) % SIZE) * SIZE + int'(elem_idx) / SIZE);
`else
    assign key_idx = wr_idx;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = elem_idx;
        if (flush) begin
            state_nxt = LOAD_Q;
            idx_nxt   = '0;
        end else if (state == FULL) begin
            state_nxt = qkv_ack ? LOAD_Q : FULL;
            idx_nxt   = '0;
        end else if (in_valid) begin
            idx_nxt   = last ? '0 : elem_idx + 1'b1;
            state_nxt = last ? state_t'(state + 2'd1) : state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD_Q;
            elem_idx  <= '0;
            qkv_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            elem_idx  <= idx_nxt;
            qkv_valid <= state_nxt == FULL;
        end
    end

    // Matrices persist across sets; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                query[i] <= '0;
                key[i]   <= '0;
                value[i] <= '0;
            end
        end else if (wr) begin
            if (state == LOAD_Q) query[wr_idx] <= in_data;
            if (state == LOAD_K) key[key_idx]  <= in_data;
            if (state == LOAD_V) value[wr_idx] <= in_data;
        end
    end
endmodule
